// File: rtl/fifo_word_reader.sv
// Pops a programmed number of DW-bit words from a show-ahead FIFO and emits each
// as DW/OW slices, MSB slice first, on a valid/ready bus. DW must be a multiple of OW.
module fifo_word_reader #(
  parameter int DW = 32,
  parameter int OW = 16,
  parameter int LW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clk7_en,
  input  logic          start,
  input  logic          abort,
  input  logic [LW-1:0] len,
  input  logic [DW-1:0] fifo_out,
  input  logic          fifo_empty,
  output logic          fifo_rd_en,
  output logic [OW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic          busy,
  output logic          done,
  output logic [1:0]    state_dbg
);

  // Handshake: a slice transfers on an enabled clk edge where out_valid and
  // out_ready are both high and abort is low; a FIFO pop happens on an enabled
  // edge where fifo_rd_en is high. Nothing moves on edges with clk7_en low.

  localparam int NS  = DW / OW;
  localparam int SCW = (NS > 1) ? $clog2(NS) : 1;
  localparam logic [SCW-1:0] SLICE_LAST = SCW'(NS - 1);
  localparam logic [SCW-1:0] SLICE_ONE  = SCW'(1);
  localparam logic [LW-1:0]  ONE_WORD   = LW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_SEND = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t         state, state_d;
  logic [DW-1:0]  shift_reg, shift_d;
  logic [SCW-1:0] slice_cnt, slice_d;
  logic [LW-1:0]  word_cnt, word_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      shift_reg <= '0;
      slice_cnt <= '0;
      word_cnt  <= '0;
    end else if (clk7_en) begin
      state     <= state_d;
      shift_reg <= shift_d;
      slice_cnt <= slice_d;
      word_cnt  <= word_d;
    end
  end

  always_comb begin
    state_d    = state;
    shift_d    = shift_reg;
    slice_d    = slice_cnt;
    word_d     = word_cnt;
    fifo_rd_en = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          word_d  = len;
          state_d = (len == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        // abort wins over a pending pop so unread words stay in the FIFO
        if (abort) begin
          word_d  = '0;
          state_d = S_DONE;
        end else if (!fifo_empty) begin
          fifo_rd_en = 1'b1;
          shift_d    = fifo_out;
          slice_d    = '0;
          state_d    = S_SEND;
        end
      end
      S_SEND: begin
        if (abort) begin
          shift_d = '0;
          slice_d = '0;
          word_d  = '0;
          state_d = S_DONE;
        end else if (out_ready) begin
          shift_d = shift_reg << OW;
          if (slice_cnt == SLICE_LAST) begin
            slice_d = '0;
            word_d  = word_cnt - ONE_WORD;
            state_d = (word_cnt == ONE_WORD) ? S_DONE : S_LOAD;
          end else begin
            slice_d = slice_cnt + SLICE_ONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign out_valid = (state == S_SEND);
  assign out_data  = out_valid ? shift_reg[DW-1 -: OW] : '0;
  assign out_last  = out_valid && (slice_cnt == SLICE_LAST) && (word_cnt == ONE_WORD);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign state_dbg = state;

endmodule

// File: tb/tb_fifo_word_reader.sv
// Directed bench for fifo_word_reader: a queue-based show-ahead FIFO model feeds
// the DUT, and a monitor scores every accepted slice against an expected queue.
module tb_fifo_word_reader;

  localparam int DW = 32;
  localparam int OW = 16;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clk7_en = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          out_ready = 1'b0;
  logic          fifo_empty = 1'b1;
  logic [LW-1:0] len = '0;
  logic [DW-1:0] fifo_out = '0;
  logic          fifo_rd_en, out_valid, out_last, busy, done;
  logic [OW-1:0] out_data;
  logic [1:0]    state_dbg;

  logic [DW-1:0] fq[$];
  logic [OW:0]   exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int pop_cnt  = 0;
  int done_cnt = 0;
  int cyc_n    = 0;
  int pop_cyc  = 0;
  int done_cyc = 0;
  logic          pop_pending = 1'b0;
  logic          prev_hold = 1'b0;
  logic [OW-1:0] prev_data = '0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  fifo_word_reader #(.DW(DW), .OW(OW), .LW(LW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clk7_en    (clk7_en),
    .start      (start),
    .abort      (abort),
    .len        (len),
    .fifo_out   (fifo_out),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done),
    .state_dbg  (state_dbg)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic void refresh();
    fifo_empty = (fq.size() == 0);
    fifo_out   = fifo_empty ? '0 : fq[0];
  endfunction

  // ---------------- FIFO model + monitor ----------------
  // Snapshots are taken 1ns after the falling edge: inputs are settled and
  // describe exactly what the DUT will see at the next rising edge.
  always @(negedge clk) begin
    logic [OW:0] e;
    cyc_n++;
    if (pop_pending) begin
      void'(fq.pop_front());
      refresh();
      pop_pending = 1'b0;
    end
    #1;
    if (rst_n && prev_hold) begin
      check("hold_valid", out_valid, 1);
      check("hold_data", out_data, prev_data);
    end
    prev_hold = rst_n && out_valid && !(clk7_en && (out_ready || abort));
    prev_data = out_data;
    if (rst_n && clk7_en && fifo_rd_en) begin
      pop_pending = 1'b1;
      pop_cnt++;
      pop_cyc = cyc_n;
    end
    if (rst_n && clk7_en && done) begin
      done_cnt++;
      done_cyc = cyc_n;
    end
    if (rst_n && clk7_en && out_valid && out_ready && !abort) begin
      check("exp_q_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("slice_data", out_data, e[OW-1:0]);
        check("slice_last", out_last, e[OW]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_word(input logic [DW-1:0] w);
    fq.push_back(w);
    refresh();
  endtask

  task automatic expect_slice(input logic last, input logic [OW-1:0] d);
    exp_q.push_back({last, d});
  endtask

  task automatic start_burst(input logic [LW-1:0] n);
    @(negedge clk);
    start = 1'b1;
    len   = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input logic toggle);
    int d0;
    bit seen;
    d0   = done_cnt;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (toggle) out_ready = ~out_ready;
      #2;
      seen = (done_cnt != d0);
    end
    check("done_seen", seen, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int p0, d0;

    // reset with enable low
    repeat (3) @(negedge clk);
    #2;
    check("rst_rd_en", fifo_rd_en, 0);
    check("rst_data", out_data, 0);
    check("rst_valid", out_valid, 0);
    check("rst_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(negedge clk);
    rst_n   = 1'b1;
    clk7_en = 1'b1;

    // single word
    out_ready = 1'b1;
    push_word(32'h12345678);
    expect_slice(1'b0, 16'h1234);
    expect_slice(1'b1, 16'h5678);
    p0 = pop_cnt;
    start_burst(8'd1);
    #2;
    check("t1_busy", busy, 1);
    check("t1_rd_en", fifo_rd_en, 1);
    check("t1_valid_early", out_valid, 0);
    wait_done(20, 1'b0);
    check("t1_pops", pop_cnt - p0, 1);
    check("t1_done_lat", done_cyc - pop_cyc, 3);
    check("t1_sb_empty", exp_q.size(), 0);

    // backpressure
    @(negedge clk);
    out_ready = 1'b0;
    push_word(32'hAAAA5555);
    push_word(32'h0F0FF0F0);
    expect_slice(1'b0, 16'hAAAA);
    expect_slice(1'b0, 16'h5555);
    expect_slice(1'b0, 16'h0F0F);
    expect_slice(1'b1, 16'hF0F0);
    p0 = pop_cnt;
    start_burst(8'd2);
    wait_done(40, 1'b1);
    check("t2_pops", pop_cnt - p0, 2);
    check("t2_sb_empty", exp_q.size(), 0);

    // empty FIFO stall
    @(negedge clk);
    out_ready = 1'b1;
    p0 = pop_cnt;
    start_burst(8'd3);
    for (int i = 0; i < 10; i++) begin
      #2;
      check("t3_gap_rd_en", fifo_rd_en, 0);
      check("t3_gap_busy", busy, 1);
      @(negedge clk);
    end
    check("t3_gap_state", state_dbg, 2'd1);
    push_word(32'h11112222);
    push_word(32'h33334444);
    push_word(32'h55556666);
    expect_slice(1'b0, 16'h1111);
    expect_slice(1'b0, 16'h2222);
    expect_slice(1'b0, 16'h3333);
    expect_slice(1'b0, 16'h4444);
    expect_slice(1'b0, 16'h5555);
    expect_slice(1'b1, 16'h6666);
    wait_done(40, 1'b0);
    check("t3_pops", pop_cnt - p0, 3);
    check("t3_sb_empty", exp_q.size(), 0);

    // abort during second slice of word 2
    push_word(32'hA1A1B1B1);
    push_word(32'hA2A2B2B2);
    push_word(32'hA3A3B3B3);
    push_word(32'hA4A4B4B4);
    expect_slice(1'b0, 16'hA1A1);
    expect_slice(1'b0, 16'hB1B1);
    expect_slice(1'b0, 16'hA2A2);
    p0 = pop_cnt;
    d0 = done_cnt;
    start_burst(8'd4);
    repeat (5) @(negedge clk);
    abort = 1'b1;
    #2;
    check("t4_abort_slice", out_data, 16'hB2B2);
    check("t4_abort_last", out_last, 0);
    @(negedge clk);
    abort = 1'b0;
    #2;
    check("t4_done", done, 1);
    check("t4_done_cnt", done_cnt - d0, 1);
    check("t4_pops", pop_cnt - p0, 2);
    check("t4_fifo_left", fq.size(), 2);
    check("t4_sb_empty", exp_q.size(), 0);
    expect_slice(1'b0, 16'hA3A3);
    expect_slice(1'b0, 16'hB3B3);
    expect_slice(1'b0, 16'hA4A4);
    expect_slice(1'b1, 16'hB4B4);
    start_burst(8'd2);
    wait_done(30, 1'b0);
    check("t4_pops_total", pop_cnt - p0, 4);
    check("t4_fifo_drained", fq.size(), 0);
    check("t4_sb_empty2", exp_q.size(), 0);

    // zero length
    p0 = pop_cnt;
    start_burst(8'd0);
    #2;
    check("t5_done", done, 1);
    check("t5_busy", busy, 1);
    check("t5_rd_en", fifo_rd_en, 0);
    @(negedge clk);
    #2;
    check("t5_done_clear", done, 0);
    check("t5_idle", busy, 0);
    check("t5_pops", pop_cnt - p0, 0);

    // clock enable held low mid-SEND
    push_word(32'hCAFEBABE);
    expect_slice(1'b0, 16'hCAFE);
    expect_slice(1'b1, 16'hBABE);
    start_burst(8'd1);
    @(negedge clk);
    clk7_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #2;
      check("t5_en_valid", out_valid, 1);
      check("t5_en_data", out_data, 16'hCAFE);
      check("t5_en_state", state_dbg, 2'd2);
      @(negedge clk);
    end
    clk7_en = 1'b1;
    wait_done(20, 1'b0);
    check("t5_sb_empty", exp_q.size(), 0);

    // reset mid-burst with enable low
    push_word(32'h01020304);
    push_word(32'h05060708);
    start_burst(8'd2);
    @(negedge clk);
    clk7_en = 1'b0;
    rst_n   = 1'b0;
    d0      = done_cnt;
    @(negedge clk);
    #2;
    check("t6_rd_en", fifo_rd_en, 0);
    check("t6_data", out_data, 0);
    check("t6_valid", out_valid, 0);
    check("t6_last", out_last, 0);
    check("t6_busy", busy, 0);
    check("t6_done", done, 0);
    check("t6_state", state_dbg, 2'd0);
    @(negedge clk);
    rst_n   = 1'b1;
    clk7_en = 1'b1;
    repeat (10) @(negedge clk);
    #2;
    check("t6_no_done", done_cnt - d0, 0);
    check("t6_idle", busy, 0);
    fq.delete();
    refresh();

    check("final_sb_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
